// File: rtl/bool_lut_sweeper_if.sv
// Signal bundle for bool_lut_sweeper: evaluation, serial LUT load, sweep control
// and the (index, value) minterm stream.
interface bool_lut_sweeper_if #(
  parameter int unsigned N = 3
) ();
  logic [N-1:0] in_x;
  logic         s;
  logic         cfg_en;
  logic         cfg_bit;
  logic         start;
  logic         busy;
  logic         done;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] m_index;
  logic         m_value;
  logic [N:0]   ones_count;

  modport master (
    output in_x, cfg_en, cfg_bit, start, m_ready,
    input  s, busy, done, m_valid, m_index, m_value, ones_count
  );

  modport slave (
    input  in_x, cfg_en, cfg_bit, start, m_ready,
    output s, busy, done, m_valid, m_index, m_value, ones_count
  );
endinterface

// File: rtl/bool_lut_sweeper.sv
// Programmable N-input Boolean function held in a serially loaded 2^N-bit LUT, with a
// registered evaluation output and a handshaked sweep over every minterm.
module bool_lut_sweeper #(
  parameter int unsigned         N         = 3,
  parameter logic [(1<<N)-1:0]   RESET_LUT = 8'h5A
) (
  input logic              clk,
  input logic              reset,
  bool_lut_sweeper_if.slave bus
);

  localparam int unsigned LutW = 1 << N;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]      r_state, w_state_d;
  logic [LutW-1:0] r_lut, w_lut_d;
  logic            r_s;
  logic [N-1:0]    r_index, w_index_d;
  logic [N:0]      r_ones, w_ones_d;

  logic w_sweep;
  logic w_xfer;
  logic w_last;
  logic w_m_value;

  assign w_sweep   = (r_state == StSweep);
  assign w_xfer    = w_sweep & bus.m_ready;
  assign w_last    = (r_index == {N{1'b1}});
  // Gated so the stream value reads 0 outside a sweep.
  assign w_m_value = w_sweep & r_lut[r_index];

  always_comb begin
    w_state_d = r_state;
    w_lut_d   = r_lut;
    w_index_d = r_index;
    w_ones_d  = r_ones;
    case (r_state)
      StIdle: begin
        // start has priority; a simultaneous cfg bit is dropped.
        if (bus.start) begin
          w_state_d = StSweep;
          w_index_d = '0;
          w_ones_d  = '0;
        end else if (bus.cfg_en) begin
          w_lut_d = {r_lut[LutW-2:0], bus.cfg_bit};
        end
      end
      StSweep: begin
        if (w_xfer) begin
          w_ones_d = r_ones + (N+1)'(w_m_value);
          if (w_last) begin
            w_state_d = StDone;
          end else begin
            w_index_d = r_index + N'(1);
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_lut   <= RESET_LUT;
      r_s     <= 1'b0;
      r_index <= '0;
      r_ones  <= '0;
    end else begin
      r_state <= w_state_d;
      r_lut   <= w_lut_d;
      r_s     <= r_lut[bus.in_x];
      r_index <= w_index_d;
      r_ones  <= w_ones_d;
    end
  end

  assign bus.s          = r_s;
  assign bus.busy       = w_sweep;
  assign bus.done       = (r_state == StDone);
  assign bus.m_valid    = w_sweep;
  assign bus.m_index    = r_index;
  assign bus.m_value    = w_m_value;
  assign bus.ones_count = r_ones;

endmodule

// File: tb/tb_bool_lut_sweeper.sv
// Scoreboard bench for bool_lut_sweeper (N=3): expected minterms are queued at start
// and compared as the stream transfers them.
module tb_bool_lut_sweeper;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_lut;
  logic [3:0] exp_q[$];

  bool_lut_sweeper_if #(.N(3)) bus ();

  bool_lut_sweeper #(
    .N(3),
    .RESET_LUT(8'h5A)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: compares the queue head every valid cycle, pops on transfer.
  always @(negedge clk) begin
    if (!reset && bus.m_valid) begin
      if (exp_q.size() == 0) begin
        check("stream_extra", {28'd0, bus.m_index, bus.m_value}, 32'hFFFF_FFFF);
      end else begin
        logic [3:0] head;
        head = exp_q[0];
        check("m_index", {29'd0, bus.m_index}, {29'd0, head[3:1]});
        check("m_value", {31'd0, bus.m_value}, {31'd0, head[0]});
        if (bus.m_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_s"},       {31'd0, bus.s},          32'd0);
    check({tag, "_busy"},    {31'd0, bus.busy},       32'd0);
    check({tag, "_done"},    {31'd0, bus.done},       32'd0);
    check({tag, "_valid"},   {31'd0, bus.m_valid},    32'd0);
    check({tag, "_index"},   {29'd0, bus.m_index},    32'd0);
    check({tag, "_value"},   {31'd0, bus.m_value},    32'd0);
    check({tag, "_ones"},    {28'd0, bus.ones_count}, 32'd0);
  endtask

  task automatic push_expected();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      exp_q.push_back({idx, model_lut[i]});
    end
  endtask

  task automatic eval_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 bus.in_x = 3'(i);
      @(posedge clk);
      @(negedge clk);
      check(tag, {31'd0, bus.s}, {31'd0, model_lut[i]});
    end
  endtask

  task automatic load_lut(input logic [7:0] bits);
    for (int j = 7; j >= 0; j--) begin
      @(posedge clk); #1 bus.cfg_en = 1'b1; bus.cfg_bit = bits[j];
    end
    @(posedge clk); #1 bus.cfg_en = 1'b0; bus.cfg_bit = 1'b0;
    model_lut = bits;
  endtask

  // mode 0: m_ready always high; mode 1: m_ready 1,0,0 repeating.
  // hold: keep start and cfg_en high through the sweep.
  task automatic do_sweep(input int mode, input bit hold, input logic [3:0] exp_ones);
    int  k = 0;
    int  busy_cyc = 0;
    bit  got = 1'b0;
    push_expected();
    @(posedge clk); #1 bus.start = 1'b1;
    if (hold) begin
      bus.cfg_en  = 1'b1;
      bus.cfg_bit = 1'b0;
    end
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      if (!hold) bus.start = 1'b0;
      bus.m_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      k++;
      @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        got = 1'b1;
        check("done_busy",  {31'd0, bus.busy},       32'd0);
        check("done_valid", {31'd0, bus.m_valid},    32'd0);
        check("ones_count", {28'd0, bus.ones_count}, {28'd0, exp_ones});
        check("q_drained",  exp_q.size(),            32'd0);
        if (mode == 0) check("busy_cycles", busy_cyc, 32'd8);
        if (hold) begin
          bus.start  = 1'b0;
          bus.cfg_en = 1'b0;
        end
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
    check("done_pulse", {31'd0, bus.done},       32'd0);
    check("idle_busy",  {31'd0, bus.busy},       32'd0);
    check("ones_hold",  {28'd0, bus.ones_count}, {28'd0, exp_ones});
    bus.m_ready = 1'b1;
  endtask

  initial begin
    int busy_seen;
    bit hit;
    reset       = 1'b0;
    bus.in_x    = '0;
    bus.cfg_en  = 1'b0;
    bus.cfg_bit = 1'b0;
    bus.start   = 1'b0;
    bus.m_ready = 1'b1;
    model_lut   = 8'h5A;
    #2 reset = 1'b1;
    #1 check_idle_zero("rst");
    @(negedge clk); reset = 1'b0;

    eval_all("eval_5a");
    do_sweep(0, 1'b0, 4'd4);

    load_lut(8'hFF);
    do_sweep(0, 1'b0, 4'd8);
    load_lut(8'h80);
    do_sweep(0, 1'b0, 4'd1);
    eval_all("eval_80");

    @(negedge clk); reset = 1'b1;
    #2 reset = 1'b0;
    model_lut = 8'h5A;
    do_sweep(1, 1'b0, 4'd4);

    do_sweep(0, 1'b1, 4'd4);
    busy_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    check("no_restart", busy_seen, 32'd0);
    eval_all("eval_frozen");

    // Abort a sweep at index 3 with an async reset.
    load_lut(8'hFF);
    push_expected();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_index == 3'd3) hit = 1'b1;
    end
    check("reach_idx3", {31'd0, hit}, 32'd1);
    reset = 1'b1;
    #1;
    check_idle_zero("abort");
    exp_q.delete();
    model_lut = 8'h5A;
    @(negedge clk); reset = 1'b0;
    do_sweep(0, 1'b0, 4'd4);
    eval_all("eval_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bool_lut_sweeper.md
Name: bool_lut_sweeper

Overview:
- Parametrised, programmable N-input Boolean function unit for the combinational-logic lab datapath.
- Holds the truth table in a 2^N-bit LUT, loaded serially.
- Provides a registered evaluation output.
- On command, sweeps every minterm in order, streams (index, value) over a valid/ready handshake and reports the count of true minterms.

Parameters:
- N, 3, number of function inputs (1..8).
- RESET_LUT, 8'h5A, truth table loaded at reset. Bit i is f(i), index = {x,y,z} with x as MSB. Width 2^N.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_x  input  N  evaluation operand.
- s  output  1  registered f(in_x).
- cfg_en  input  1  LUT shift enable.
- cfg_bit  input  1  LUT serial data.
- start  input  1  sweep request (single-cycle pulse or level).
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at sweep completion.
- m_valid  output  1  minterm stream valid.
- m_ready  input  1  minterm stream ready.
- m_index  output  N  current minterm index.
- m_value  output  1  f(m_index).
- ones_count  output  N+1  number of true minterms counted.

Behaviour:
- Reset (async, active-high), applied immediately, including mid-sweep:
  - lut=RESET_LUT.
  - state=IDLE.
  - s=0, busy=0, done=0, m_valid=0, m_index=0, m_value=0, ones_count=0.
- Evaluation:
  - s <= lut[in_x] every cycle, independent of state.
  - Latency 1 clock.
  - Uses the LUT contents before any same-edge shift.
- LUT load:
  - In IDLE with cfg_en=1: lut <= {lut[2^N-2:0], cfg_bit}.
  - The first of 2^N bits shifted lands at index 2^N-1 (MSB-first load).
  - cfg_en is ignored in SWEEP and DONE; the LUT stays frozen during a sweep.
- States: IDLE, SWEEP, DONE.
  - IDLE:
    - If start=1: go to SWEEP; m_index<=0, ones_count<=0, busy<=1.
    - If start and cfg_en are both 1, start wins and the cfg bit is dropped.
  - SWEEP:
    - m_valid=1.
    - m_value=lut[m_index], combinational from the registered index.
    - Transfer occurs on m_valid & m_ready: ones_count += m_value.
      - If m_index==2^N-1: go to DONE.
      - Otherwise m_index++.
    - While m_ready=0: m_index, m_value and ones_count hold stable.
  - DONE:
    - Lasts exactly one cycle: done=1, m_valid=0, busy=0.
    - Then return to IDLE.
- start in SWEEP or DONE is ignored, with no restart and no queuing.
- ones_count holds its final value in IDLE until the next start clears it.
- ones_count width N+1, so an all-ones LUT yields 2^N without overflow.
- m_index does not wrap during a sweep; it stops at 2^N-1.
- Sweep length with m_ready tied high: 2^N SWEEP cycles + 1 DONE cycle. busy is high for 2^N cycles.

Test Plan:
- Reset, no load (N=3), in_x swept 0..7 -> s one cycle later = 0,1,0,1,1,0,1,0 (LUT 8'h5A).
- Reset, start pulse, m_ready=1 -> m_index 0..7 on consecutive cycles, m_value=0,1,0,1,1,0,1,0, then done pulses for one cycle, ones_count=4, busy low.
- Shift 8 bits of 1 with cfg_en, then start with m_ready=1 -> ones_count=8 (4'b1000). Shifting 8'b1000_0000 MSB-first -> only index 7 true, ones_count=1.
- m_ready toggled 1,0,0,1,... during a sweep -> m_index and m_value frozen during stalls, no minterm skipped or repeated, final ones_count=4.
- cfg_en=1 and start held during SWEEP -> LUT unchanged (post-sweep evaluation still matches 8'h5A) and no second sweep starts after DONE unless start is re-asserted in IDLE.
- Assert reset at m_index=3 of a sweep -> busy, m_valid, ones_count and m_index go to 0 immediately; LUT back to 8'h5A; the next start sweeps from index 0.
